// File: rtl/if_fetch_ctrl_if.sv
// Fetch front-end bus: redirect input, ROM request/response and the
// {pc,inst} valid/ready handoff towards decode.
interface if_fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  flush_i;
  logic [31:0]           flush_pc_i;
  logic                  rom_en_o;
  logic [ADDR_WIDTH-1:0] rom_addr_o;
  logic [31:0]           rom_data_i;
  logic                  if_valid_o;
  logic                  if_ready_i;
  logic [31:0]           if_pc_o;
  logic [31:0]           if_inst_o;

  // Fetch controller side
  modport master (
    input  flush_i, flush_pc_i, rom_data_i, if_ready_i,
    output rom_en_o, rom_addr_o, if_valid_o, if_pc_o, if_inst_o
  );

  // ROM / decode / redirect side
  modport slave (
    output flush_i, flush_pc_i, rom_data_i, if_ready_i,
    input  rom_en_o, rom_addr_o, if_valid_o, if_pc_o, if_inst_o
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch front end. Owns the PC, issues reads to a synchronous
// ROM with one cycle of latency, pairs each returned word with its PC and
// buffers up to two results in a shift-style skid FIFO feeding decode.
// Entry 0 of the FIFO is always the head, so the outputs come straight
// from registers.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 12
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_ctrl_if.master bus
);

  logic [31:0] pc_reg;
  logic [31:0] req_pc_reg;
  logic        inflight_reg;
  logic [1:0]  count_reg;
  logic [1:0]  count_next;
  logic [31:0] e0_pc_reg,   e0_pc_next;
  logic [31:0] e0_inst_reg, e0_inst_next;
  logic [31:0] e1_pc_reg,   e1_pc_next;
  logic [31:0] e1_inst_reg, e1_inst_next;

  logic [31:0] fetch_pc;
  logic [2:0]  occupancy;
  logic        head_valid;
  logic        pop;
  logic        push;
  logic        issue;

  // A redirect takes effect in the same cycle: the ROM is addressed with
  // the (word-aligned) target instead of the sequential PC.
  assign fetch_pc   = bus.flush_i ? (bus.flush_pc_i & 32'hFFFF_FFFC) : pc_reg;
  assign head_valid = (count_reg != 2'd0);
  // A flush makes the offered head wrong-path, so it is never consumed.
  assign pop        = head_valid & bus.if_ready_i & ~bus.flush_i;
  // The word returning this cycle is dropped when a flush is present.
  assign push       = inflight_reg & ~bus.flush_i;
  // Buffered plus outstanding words never exceed the FIFO depth; a pop
  // frees a slot for the word issued in the same cycle.
  assign occupancy  = {1'b0, count_reg} + {2'b00, inflight_reg};
  assign issue      = ~rst & (bus.flush_i | (occupancy < 3'd2) | pop);

  assign bus.rom_en_o   = issue;
  assign bus.rom_addr_o = fetch_pc[ADDR_WIDTH+1:2];
  assign bus.if_valid_o = head_valid;
  assign bus.if_pc_o    = e0_pc_reg;
  assign bus.if_inst_o  = e0_inst_reg;

  // PC advance and tracking of the single outstanding ROM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg       <= RESET_PC & 32'hFFFF_FFFC;
      req_pc_reg   <= 32'h0;
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        pc_reg     <= fetch_pc + 32'd4;
        req_pc_reg <= fetch_pc;
      end
    end
  end

  // Next FIFO contents: flush clears, otherwise push/pop with entry 0 as head.
  always_comb begin
    count_next   = count_reg;
    e0_pc_next   = e0_pc_reg;
    e0_inst_next = e0_inst_reg;
    e1_pc_next   = e1_pc_reg;
    e1_inst_next = e1_inst_reg;
    if (bus.flush_i) begin
      count_next = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) begin
            e0_pc_next   = req_pc_reg;
            e0_inst_next = bus.rom_data_i;
          end else begin
            e1_pc_next   = req_pc_reg;
            e1_inst_next = bus.rom_data_i;
          end
          count_next = count_reg + 2'd1;
        end
        2'b01: begin
          // Emptying the last entry leaves the head registers untouched.
          if (count_reg == 2'd2) begin
            e0_pc_next   = e1_pc_reg;
            e0_inst_next = e1_inst_reg;
          end
          count_next = count_reg - 2'd1;
        end
        2'b11: begin
          if (count_reg == 2'd1) begin
            e0_pc_next   = req_pc_reg;
            e0_inst_next = bus.rom_data_i;
          end else begin
            e0_pc_next   = e1_pc_reg;
            e0_inst_next = e1_inst_reg;
            e1_pc_next   = req_pc_reg;
            e1_inst_next = bus.rom_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  // FIFO state registers; cleared asynchronously so outputs read zero in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg   <= 2'd0;
      e0_pc_reg   <= 32'h0;
      e0_inst_reg <= 32'h0;
      e1_pc_reg   <= 32'h0;
      e1_inst_reg <= 32'h0;
    end else begin
      count_reg   <= count_next;
      e0_pc_reg   <= e0_pc_next;
      e0_inst_reg <= e0_inst_next;
      e1_pc_reg   <= e1_pc_next;
      e1_inst_reg <= e1_inst_next;
    end
  end

  // Buffered plus outstanding words must always fit in the two entries.
  assert property (@(posedge clk) disable iff (rst) occupancy <= 3'd2);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed testbench for if_fetch_ctrl. Two instances: one with the default
// reset PC for streaming/stall/flush/reset scenarios, one starting near the
// top of the address space for PC and ROM-address wrap. ROM[i] = i.
module tb_if_fetch_ctrl;

  logic clk;
  logic rst;
  logic rst_w;
  int   n_checks;
  int   n_fail;
  logic [31:0] rom [4096];

  if_fetch_ctrl_if #(.ADDR_WIDTH(12)) bus ();
  if_fetch_ctrl_if #(.ADDR_WIDTH(12)) busw ();

  if_fetch_ctrl #(.RESET_PC(32'h0000_0000), .ADDR_WIDTH(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  if_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .ADDR_WIDTH(12)) dut_w (
    .clk (clk),
    .rst (rst_w),
    .bus (busw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM models, one cycle read latency
  always @(posedge clk) if (bus.rom_en_o)  bus.rom_data_i  <= rom[bus.rom_addr_o];
  always @(posedge clk) if (busw.rom_en_o) busw.rom_data_i <= rom[busw.rom_addr_o];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) tick();
    n_checks++; if (bus.if_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.if_valid_o); end
    n_checks++; if (bus.if_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 00000000", bus.if_pc_o); end
    n_checks++; if (bus.if_inst_o !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h expected 00000000", bus.if_inst_o); end
    n_checks++; if (bus.rom_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_rom_en: got %b expected 0", bus.rom_en_o); end
    n_checks++; if (busw.rom_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_rom_en_w: got %b expected 0", busw.rom_en_o); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.rom_en_o !== 1'b1) begin n_fail++; $display("FAIL release_rom_en: got %b expected 1", bus.rom_en_o); end
    n_checks++; if (bus.rom_addr_o !== 12'h000) begin n_fail++; $display("FAIL release_addr: got %h expected 000", bus.rom_addr_o); end
    $display("test_reset done");
  endtask

  task automatic test_stream;
    logic [11:0] exp_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_addr = 12'(k);
      n_checks++; if (bus.rom_addr_o !== exp_addr) begin n_fail++; $display("FAIL stream_addr[%0d]: got %h expected %h", k, bus.rom_addr_o, exp_addr); end
      if (k == 1) begin
        n_checks++; if (bus.if_valid_o !== 1'b0) begin n_fail++; $display("FAIL stream_first_valid: got %b expected 0", bus.if_valid_o); end
      end else begin
        exp_pc   = 32'(4 * (k - 2));
        exp_inst = 32'(k - 2);
        n_checks++; if (bus.if_valid_o !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, bus.if_valid_o); end
        n_checks++; if (bus.if_pc_o !== exp_pc) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, bus.if_pc_o, exp_pc); end
        n_checks++; if (bus.if_inst_o !== exp_inst) begin n_fail++; $display("FAIL stream_inst[%0d]: got %h expected %h", k, bus.if_inst_o, exp_inst); end
      end
    end
    $display("test_stream done");
  endtask

  task automatic test_stall;
    logic [31:0] exp_pc;
    bus.if_ready_i = 1'b0;
    #1;
    n_checks++; if (bus.rom_en_o !== 1'b0) begin n_fail++; $display("FAIL stall_rom_en_drop: got %b expected 0", bus.rom_en_o); end
    for (int j = 0; j < 5; j++) begin
      tick();
      n_checks++; if (bus.rom_en_o !== 1'b0) begin n_fail++; $display("FAIL stall_rom_en[%0d]: got %b expected 0", j, bus.rom_en_o); end
      n_checks++; if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 32'hC || bus.if_inst_o !== 32'h3) begin
        n_fail++; $display("FAIL stall_head[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=0000000c inst=00000003", j, bus.if_valid_o, bus.if_pc_o, bus.if_inst_o);
      end
    end
    bus.if_ready_i = 1'b1;
    #1;
    n_checks++; if (bus.rom_en_o !== 1'b1 || bus.rom_addr_o !== 12'h005) begin
      n_fail++; $display("FAIL stall_resume_issue: got en=%b addr=%h expected en=1 addr=005", bus.rom_en_o, bus.rom_addr_o);
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      exp_pc = 32'h10 + 32'(4 * j);
      n_checks++; if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== exp_pc || bus.if_inst_o !== 32'(4 + j)) begin
        n_fail++; $display("FAIL stall_resume[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%0d", j, bus.if_valid_o, bus.if_pc_o, bus.if_inst_o, exp_pc, 4 + j);
      end
    end
    $display("test_stall done");
  endtask

  task automatic test_flush_full;
    bus.if_ready_i = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.rom_en_o !== 1'b0 || bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 32'h18) begin
      n_fail++; $display("FAIL full_state: got en=%b v=%b pc=%h expected en=0 v=1 pc=00000018", bus.rom_en_o, bus.if_valid_o, bus.if_pc_o);
    end
    bus.flush_i    = 1'b1;
    bus.flush_pc_i = 32'h100;
    #1;
    n_checks++; if (bus.rom_en_o !== 1'b1 || bus.rom_addr_o !== 12'h040) begin
      n_fail++; $display("FAIL full_flush_issue: got en=%b addr=%h expected en=1 addr=040", bus.rom_en_o, bus.rom_addr_o);
    end
    tick();
    bus.flush_i    = 1'b0;
    bus.if_ready_i = 1'b1;
    #1;
    n_checks++; if (bus.if_valid_o !== 1'b0) begin n_fail++; $display("FAIL full_flush_bubble: got %b expected 0", bus.if_valid_o); end
    n_checks++; if (bus.rom_addr_o !== 12'h041) begin n_fail++; $display("FAIL full_flush_next_addr: got %h expected 041", bus.rom_addr_o); end
    tick();
    n_checks++; if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 32'h100 || bus.if_inst_o !== 32'd64) begin
      n_fail++; $display("FAIL full_flush_target: got v=%b pc=%h inst=%h expected v=1 pc=00000100 inst=00000040", bus.if_valid_o, bus.if_pc_o, bus.if_inst_o);
    end
    tick();
    n_checks++; if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 32'h104 || bus.if_inst_o !== 32'd65) begin
      n_fail++; $display("FAIL full_flush_target2: got v=%b pc=%h inst=%h expected v=1 pc=00000104 inst=00000041", bus.if_valid_o, bus.if_pc_o, bus.if_inst_o);
    end
    $display("test_flush_full done");
  endtask

  task automatic test_flush_pop;
    bus.flush_i    = 1'b1;
    bus.flush_pc_i = 32'h103;
    #1;
    n_checks++; if (bus.rom_en_o !== 1'b1 || bus.rom_addr_o !== 12'h040) begin
      n_fail++; $display("FAIL pop_flush_issue: got en=%b addr=%h expected en=1 addr=040", bus.rom_en_o, bus.rom_addr_o);
    end
    tick();
    bus.flush_i = 1'b0;
    n_checks++; if (bus.if_valid_o !== 1'b0) begin n_fail++; $display("FAIL pop_flush_bubble: got %b expected 0", bus.if_valid_o); end
    tick();
    n_checks++; if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 32'h100 || bus.if_inst_o !== 32'd64) begin
      n_fail++; $display("FAIL pop_flush_target: got v=%b pc=%h inst=%h expected v=1 pc=00000100 inst=00000040", bus.if_valid_o, bus.if_pc_o, bus.if_inst_o);
    end
    tick();
    n_checks++; if (bus.if_pc_o !== 32'h104 || bus.if_inst_o !== 32'd65) begin
      n_fail++; $display("FAIL pop_flush_next: got pc=%h inst=%h expected pc=00000104 inst=00000041", bus.if_pc_o, bus.if_inst_o);
    end
    $display("test_flush_pop done");
  endtask

  task automatic test_back_to_back;
    bus.flush_i    = 1'b1;
    bus.flush_pc_i = 32'h200;
    tick();
    bus.flush_pc_i = 32'h300;
    #1;
    n_checks++; if (bus.if_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_first_bubble: got %b expected 0", bus.if_valid_o); end
    n_checks++; if (bus.rom_addr_o !== 12'h0C0) begin n_fail++; $display("FAIL b2b_second_addr: got %h expected 0c0", bus.rom_addr_o); end
    tick();
    bus.flush_i = 1'b0;
    n_checks++; if (bus.if_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_second_bubble: got %b expected 0", bus.if_valid_o); end
    tick();
    n_checks++; if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 32'h300 || bus.if_inst_o !== 32'hC0) begin
      n_fail++; $display("FAIL b2b_target: got v=%b pc=%h inst=%h expected v=1 pc=00000300 inst=000000c0", bus.if_valid_o, bus.if_pc_o, bus.if_inst_o);
    end
    tick();
    n_checks++; if (bus.if_pc_o !== 32'h304 || bus.if_inst_o !== 32'hC1) begin
      n_fail++; $display("FAIL b2b_next: got pc=%h inst=%h expected pc=00000304 inst=000000c1", bus.if_pc_o, bus.if_inst_o);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_async_reset;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.if_valid_o !== 1'b0 || bus.if_pc_o !== 32'h0 || bus.if_inst_o !== 32'h0 || bus.rom_en_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_outputs: got v=%b pc=%h inst=%h en=%b expected all zero", bus.if_valid_o, bus.if_pc_o, bus.if_inst_o, bus.rom_en_o);
    end
    tick();
    n_checks++; if (bus.if_valid_o !== 1'b0 || bus.rom_en_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_hold: got v=%b en=%b expected 0 0", bus.if_valid_o, bus.rom_en_o);
    end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.rom_en_o !== 1'b1 || bus.rom_addr_o !== 12'h000) begin
      n_fail++; $display("FAIL async_restart_issue: got en=%b addr=%h expected en=1 addr=000", bus.rom_en_o, bus.rom_addr_o);
    end
    tick();
    n_checks++; if (bus.if_valid_o !== 1'b0) begin n_fail++; $display("FAIL async_restart_latency: got %b expected 0", bus.if_valid_o); end
    tick();
    n_checks++; if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 32'h0 || bus.if_inst_o !== 32'h0) begin
      n_fail++; $display("FAIL async_restart_first: got v=%b pc=%h inst=%h expected v=1 pc=00000000 inst=00000000", bus.if_valid_o, bus.if_pc_o, bus.if_inst_o);
    end
    tick();
    n_checks++; if (bus.if_pc_o !== 32'h4 || bus.if_inst_o !== 32'h1) begin
      n_fail++; $display("FAIL async_restart_second: got pc=%h inst=%h expected pc=00000004 inst=00000001", bus.if_pc_o, bus.if_inst_o);
    end
    $display("test_async_reset done");
  endtask

  task automatic test_wrap;
    logic [11:0] exp_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    rst_w = 1'b0;
    #1;
    n_checks++; if (busw.rom_en_o !== 1'b1 || busw.rom_addr_o !== 12'hFFE) begin
      n_fail++; $display("FAIL wrap_first_addr: got en=%b addr=%h expected en=1 addr=ffe", busw.rom_en_o, busw.rom_addr_o);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_addr = 12'hFFE + 12'(k);
      n_checks++; if (busw.rom_addr_o !== exp_addr) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h expected %h", k, busw.rom_addr_o, exp_addr); end
      if (k >= 2) begin
        exp_pc   = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
        exp_inst = {20'h0, 12'hFFE + 12'(k - 2)};
        n_checks++; if (busw.if_valid_o !== 1'b1 || busw.if_pc_o !== exp_pc || busw.if_inst_o !== exp_inst) begin
          n_fail++; $display("FAIL wrap_head[%0d]: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h", k, busw.if_valid_o, busw.if_pc_o, busw.if_inst_o, exp_pc, exp_inst);
        end
      end
    end
    $display("test_wrap done");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 4096; i++) rom[i] = 32'(i);
    rst             = 1'b1;
    rst_w           = 1'b1;
    bus.flush_i     = 1'b0;
    bus.flush_pc_i  = 32'h0;
    bus.if_ready_i  = 1'b1;
    busw.flush_i    = 1'b0;
    busw.flush_pc_i = 32'h0;
    busw.if_ready_i = 1'b1;

    test_reset();
    test_stream();
    test_stall();
    test_flush_full();
    test_flush_pop();
    test_back_to_back();
    test_async_reset();
    test_wrap();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
